// File: rtl/hs_pkg.sv
// Shared definitions for the handshake CDC receive path (synchronizer and rx buffer).
// Receive FSM encodings are plain 2-bit constants so legacy tools and waveforms decode them identically.
package hs_pkg;

    localparam int HS_DW = 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD     = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    // Encoding 3 is unreachable; the FSM maps it back to IDLE.
    function automatic logic hs_state_legal(input logic [1:0] st);
        return (st == IDLE) || (st == LOAD) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/hs_rx_buffer_if.sv
// Bundle of the synchronizer-facing handshake, the consumer stream and the status outputs.
// slave = the rx buffer, master = whatever drives the synchronizer side and consumes the stream.
interface hs_rx_buffer_if
    import hs_pkg::*;
#(
    parameter int DW    = HS_DW,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0]   bdata;
    logic            bvalid;
    logic            bload;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic [CW-1:0]   fifo_cnt;
    logic            full;
    logic            empty;
    logic [CNTW-1:0] rx_cnt;

    modport slave (
        input  bdata, bvalid, m_ready,
        output bload, m_data, m_valid, fifo_cnt, full, empty, rx_cnt
    );

    modport master (
        output bdata, bvalid, m_ready,
        input  bload, m_data, m_valid, fifo_cnt, full, empty, rx_cnt
    );

endinterface

// File: rtl/hs_sync_fifo.sv
// Single-clock register-array FIFO with first-word fall-through read data.
// Latency: a pushed word is visible on pop_data the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; the owner is expected to gate both.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DW    = HS_DW,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          bclk,
    input  logic          brst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 on their own.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (!brst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge bclk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/hs_rx_buffer.sv
// Captures each word offered by the handshake synchronizer, acks it with one bload pulse, queues it.
// Latency: capture on the edge bvalid is seen in IDLE; m_valid next cycle if empty; bload 1 cycle after capture.
// Backpressure: while the FIFO is full the FSM idles without acking, so the synchronizer holds bvalid/bdata.
module hs_rx_buffer
    import hs_pkg::*;
#(
    parameter int DW    = HS_DW,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic          bclk,
    input  logic          brst_n,
    hs_rx_buffer_if.slave rx
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]      state_q, state_d;
    logic            bload_q, bload_d;
    logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    logic [DW-1:0]   pop_data;

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        rx_cnt_d = rx_cnt_q;

        case (state_q)
            IDLE: begin
                // Full is this cycle's value, so a same-cycle pop does not open a slot.
                if (rx.bvalid && !fifo_full) begin
                    push     = 1'b1;
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rx.bvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!hs_state_legal(state_d)) begin
            state_d = IDLE;
        end

        bload_d = (state_d == LOAD);
    end

    always_ff @(posedge bclk) begin
        if (!brst_n) begin
            state_q  <= IDLE;
            bload_q  <= 1'b0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            bload_q  <= bload_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign pop = rx.m_ready && !fifo_empty;

    hs_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .bclk      (bclk),
        .brst_n    (brst_n),
        .push      (push),
        .push_data (rx.bdata),
        .pop       (pop),
        .pop_data  (pop_data),
        .cnt       (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx.bload    = bload_q;
    assign rx.m_data   = pop_data;
    assign rx.m_valid  = !fifo_empty;
    assign rx.fifo_cnt = fifo_cnt;
    assign rx.full     = fifo_full;
    assign rx.empty    = fifo_empty;
    assign rx.rx_cnt   = rx_cnt_q;

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Directed bench for hs_rx_buffer: a vector table for reset/single-word timing plus hand sequences.
module tb_hs_rx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;

    logic bclk = 1'b0;
    logic brst_n;

    always #5 bclk = ~bclk;

    hs_rx_buffer_if #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    hs_rx_buffer #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .bclk   (bclk),
        .brst_n (brst_n),
        .rx     (bus)
    );

    typedef struct {
        logic       rst_n;
        logic       bvalid;
        logic [7:0] bdata;
        logic       m_ready;
        logic       e_bload;
        logic       e_mvalid;
        logic [7:0] e_mdata;
        logic [2:0] e_cnt;
        logic       e_full;
        logic       e_empty;
        logic [3:0] e_rx;
    } vec_t;

    vec_t       tbl [11];
    int         n_vec   = 0;
    int         n_err   = 0;
    int         n_bload = 0;
    logic [7:0] got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Records any word handed over at the coming edge, then samples 1 time unit after it.
    task automatic tick();
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got.push_back(bus.m_data);
        @(posedge bclk);
        #1;
        if (bus.bload === 1'b1) n_bload++;
    endtask

    task automatic do_reset();
        brst_n      = 1'b0;
        bus.bvalid  = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        brst_n = 1'b1;
        got.delete();
        n_bload = 0;
    endtask

    task automatic send_word(input logic [7:0] d);
        bus.bvalid = 1'b1;
        bus.bdata  = d;
        tick();
        chk("send_bload_pulse", 32'(bus.bload), 32'd1);
        tick();
        chk("send_bload_single", 32'(bus.bload), 32'd0);
        bus.bvalid = 1'b0;
        tick();
    endtask

    initial begin
        brst_n      = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bdata   = 8'h00;
        bus.m_ready = 1'b0;

        //         rst  bv   bdata  rdy   bload mv   mdata  cnt   full  empty rx
        tbl[0]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0, 4'd1};
        tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd1};
        tbl[4]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd1};
        tbl[5]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd1};
        tbl[7]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd1};
        tbl[8]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1, 1'b0, 1'b0, 4'd2};
        tbl[9]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'd0};

        // Reset with bvalid high, single word A5, then a reset that discards a queued word.
        for (int i = 0; i < 11; i++) begin
            brst_n      = tbl[i].rst_n;
            bus.bvalid  = tbl[i].bvalid;
            bus.bdata   = tbl[i].bdata;
            bus.m_ready = tbl[i].m_ready;
            tick();
            chk($sformatf("vec%0d_bload", i),   32'(bus.bload),    32'(tbl[i].e_bload));
            chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid),  32'(tbl[i].e_mvalid));
            chk($sformatf("vec%0d_cnt", i),     32'(bus.fifo_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_full", i),    32'(bus.full),     32'(tbl[i].e_full));
            chk($sformatf("vec%0d_empty", i),   32'(bus.empty),    32'(tbl[i].e_empty));
            chk($sformatf("vec%0d_rx_cnt", i),  32'(bus.rx_cnt),   32'(tbl[i].e_rx));
            if (tbl[i].e_mvalid) chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(tbl[i].e_mdata));
        end

        // Fill to full, stall a fifth word, then drain.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_word(8'(i));
            chk("fill_cnt", 32'(bus.fifo_cnt), 32'(i));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        bus.bvalid = 1'b1;
        bus.bdata  = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_bload", 32'(bus.bload), 32'd0);
            chk("full_hold_rx", 32'(bus.rx_cnt), 32'd4);
        end
        bus.m_ready = 1'b1;
        tick();
        chk("no_pop_through_bload", 32'(bus.bload), 32'd0);
        chk("no_pop_through_cnt", 32'(bus.fifo_cnt), 32'd3);
        tick();
        chk("resume_bload", 32'(bus.bload), 32'd1);
        chk("resume_cnt", 32'(bus.fifo_cnt), 32'd3);
        tick();
        bus.bvalid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("fill_rx_cnt", 32'(bus.rx_cnt), 32'd5);
        chk("fill_n_words", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) chk($sformatf("fill_order%0d", i), 32'(got[i]), 32'(i + 1));
        end
        chk("fill_bloads", 32'(n_bload), 32'd5);

        // Push and pop on the same edge with two words queued.
        do_reset();
        send_word(8'h11);
        send_word(8'h22);
        chk("pp_pre_cnt", 32'(bus.fifo_cnt), 32'd2);
        bus.bvalid  = 1'b1;
        bus.bdata   = 8'h33;
        bus.m_ready = 1'b1;
        tick();
        chk("pp_cnt", 32'(bus.fifo_cnt), 32'd2);
        chk("pp_bload", 32'(bus.bload), 32'd1);
        tick();
        bus.bvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pp_n_words", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("pp_order0", 32'(got[0]), 32'h11);
            chk("pp_order1", 32'(got[1]), 32'h22);
            chk("pp_order2", 32'(got[2]), 32'h33);
        end

        // bvalid stuck high for 20 cycles.
        do_reset();
        bus.m_ready = 1'b1;
        bus.bvalid  = 1'b1;
        bus.bdata   = 8'h3C;
        for (int i = 0; i < 20; i++) tick();
        bus.bvalid = 1'b0;
        tick();
        tick();
        chk("stuck_bloads", 32'(n_bload), 32'd1);
        chk("stuck_rx_cnt", 32'(bus.rx_cnt), 32'd1);
        chk("stuck_n_words", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("stuck_data", 32'(got[0]), 32'h3C);

        // 17 words through a 4-bit rx_cnt: counter and pointers both wrap.
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_word(8'h40 + 8'(i));
            chk($sformatf("wrap_rx%0d", i), 32'(bus.rx_cnt), 32'((i + 1) % 16));
        end
        tick();
        chk("wrap_rx_cnt", 32'(bus.rx_cnt), 32'd1);
        chk("wrap_bloads", 32'(n_bload), 32'd17);
        chk("wrap_n_words", 32'(got.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < got.size()) chk($sformatf("wrap_order%0d", i), 32'(got[i]), 32'h40 + 32'(i));
        end
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
